// File: rtl/mont_exp_if.sv
// Handshake bundle between the command layer, mont_exp_ctrl and the
// pipelined Montgomery multiplier.
interface mont_exp_if #(
  parameter int NBITS = 2048,
  parameter int EBITS = NBITS
);
  logic             start_p;
  logic [NBITS-1:0] base_m;
  logic [NBITS-1:0] one_m;
  logic [EBITS-1:0] exp;
  logic [NBITS-1:0] m;
  logic [NBITS-1:0] result;
  logic             busy;
  logic             done_p;
  logic [NBITS-1:0] mul_a;
  logic [NBITS-1:0] mul_b;
  logic [NBITS-1:0] mul_m;
  logic             mul_enable_p;
  logic [NBITS-1:0] mul_y;
  logic             mul_done_p;

  modport slave (
    input  start_p, base_m, one_m, exp, m, mul_y, mul_done_p,
    output result, busy, done_p, mul_a, mul_b, mul_m, mul_enable_p
  );

  modport master (
    output start_p, base_m, one_m, exp, m, mul_y, mul_done_p,
    input  result, busy, done_p, mul_a, mul_b, mul_m, mul_enable_p
  );
endinterface

// File: rtl/mont_exp_ctrl.sv
// Left-to-right square-and-multiply sequencer for a pipelined Montgomery multiplier.
// MONT_EXP_SKIP_LZ_EN: adds a SCAN state that skips leading zero exponent bits.
module mont_exp_ctrl #(
  parameter int NBITS = 2048,
  parameter int EBITS = NBITS
) (
  input  logic       clk,
  input  logic       rst_n,
  mont_exp_if.slave  bus
);
  localparam int IW = (EBITS > 1) ? $clog2(EBITS) : 1;
  localparam logic [IW-1:0] IDX_MAX = IW'(EBITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
`ifdef MONT_EXP_SKIP_LZ_EN
    S_SCAN,
`endif
    S_SQR_ISSUE,
    S_SQR_WAIT,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [NBITS-1:0] r_acc;
  logic [NBITS-1:0] r_base;
  logic [EBITS-1:0] r_exp;
  logic [NBITS-1:0] r_m;
  logic [IW-1:0]    r_idx;
  logic [NBITS-1:0] r_result;
  logic [NBITS-1:0] r_mul_a;
  logic [NBITS-1:0] r_mul_b;
  logic             r_mul_enable_p;
  logic             r_busy;
  logic             r_done_p;

  wire w_bit = r_exp[r_idx];

  // Issue strobes and operands are loaded on the edge that enters an ISSUE
  // state, so the pulse coincides with that state and operands stay put after.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_acc          <= '0;
      r_base         <= '0;
      r_exp          <= '0;
      r_m            <= '0;
      r_idx          <= '0;
      r_result       <= '0;
      r_mul_a        <= '0;
      r_mul_b        <= '0;
      r_mul_enable_p <= 1'b0;
      r_busy         <= 1'b0;
      r_done_p       <= 1'b0;
    end else begin
      r_mul_enable_p <= 1'b0;
      r_done_p       <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start_p) begin
            r_acc  <= bus.one_m;
            r_base <= bus.base_m;
            r_exp  <= bus.exp;
            r_m    <= bus.m;
            r_idx  <= IDX_MAX;
            r_busy <= 1'b1;
`ifdef MONT_EXP_SKIP_LZ_EN
            r_state <= S_SCAN;
`else
            r_state        <= S_SQR_ISSUE;
            r_mul_a        <= bus.one_m;
            r_mul_b        <= bus.one_m;
            r_mul_enable_p <= 1'b1;
`endif
          end
        end
`ifdef MONT_EXP_SKIP_LZ_EN
        S_SCAN: begin
          if (w_bit) begin
            r_state        <= S_MUL_ISSUE;
            r_mul_a        <= r_acc;
            r_mul_b        <= r_base;
            r_mul_enable_p <= 1'b1;
          end else if (r_idx == '0) begin
            r_state  <= S_DONE;
            r_result <= r_acc;
            r_done_p <= 1'b1;
          end else begin
            r_idx <= r_idx - 1'b1;
          end
        end
`endif
        S_SQR_ISSUE: r_state <= S_SQR_WAIT;
        S_MUL_ISSUE: r_state <= S_MUL_WAIT;
        S_SQR_WAIT, S_MUL_WAIT: begin
          if (bus.mul_done_p) begin
            r_acc <= bus.mul_y;
            if (r_state == S_SQR_WAIT && w_bit) begin
              r_state        <= S_MUL_ISSUE;
              r_mul_a        <= bus.mul_y;
              r_mul_b        <= r_base;
              r_mul_enable_p <= 1'b1;
            end else if (r_idx == '0) begin
              r_state  <= S_DONE;
              r_result <= bus.mul_y;
              r_done_p <= 1'b1;
            end else begin
              r_idx          <= r_idx - 1'b1;
              r_state        <= S_SQR_ISSUE;
              r_mul_a        <= bus.mul_y;
              r_mul_b        <= bus.mul_y;
              r_mul_enable_p <= 1'b1;
            end
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.result       = r_result;
  assign bus.busy         = r_busy;
  assign bus.done_p       = r_done_p;
  assign bus.mul_a        = r_mul_a;
  assign bus.mul_b        = r_mul_b;
  assign bus.mul_m        = r_m;
  assign bus.mul_enable_p = r_mul_enable_p;
endmodule

// File: tb/tb_mont_exp_ctrl.sv
// Directed bench for mont_exp_ctrl: m=13, R=256 (R mod m = 9, R^-1 mod m = 3),
// behavioural multiplier with latency 3.
module tb_mont_exp_ctrl;
  localparam int NB = 8;
  localparam int EB = 4;
  localparam int D  = 3;

`ifdef MONT_EXP_SKIP_LZ_EN
  localparam int E5_NP = 4, E5_FIRST = 3, E5_DONE = 19;
  localparam int E0_NP = 0, E0_DONE = 5;
`else
  localparam int E5_NP = 6, E5_FIRST = 1, E5_DONE = 25;
  localparam int E0_NP = 4, E0_DONE = 17;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  mont_exp_if #(.NBITS(NB), .EBITS(EB)) bus ();

  mont_exp_ctrl #(.NBITS(NB), .EBITS(EB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // cycle k of a run = k-th cycle after the edge that accepted start_p
  int n_edges = 0;
  int t0 = 0;
  always @(posedge clk) n_edges++;

  int         pulses[$];
  int         n_done = 0;
  int         done_cyc = -1;
  logic [7:0] done_res;
  logic       done_busy;

  always @(negedge clk) begin
    if (bus.mul_enable_p === 1'b1) pulses.push_back(n_edges - t0 + 1);
    if (bus.done_p === 1'b1) begin
      n_done++;
      done_cyc  = n_edges - t0 + 1;
      done_res  = bus.result;
      done_busy = bus.busy;
    end
  end

  // Multiplier model: y = a*b*R^-1 mod 13, done D cycles after issue
  int         m_cnt = 0;
  logic [7:0] m_pend = '0;
  logic       inj = 1'b0;

  always @(negedge clk) begin
    bus.mul_done_p = 1'b0;
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) begin
        bus.mul_done_p = 1'b1;
        bus.mul_y      = m_pend;
      end
    end
    if (inj) begin
      bus.mul_done_p = 1'b1;
      bus.mul_y      = 8'h55;
    end
    if (bus.mul_enable_p === 1'b1) begin
      m_cnt  = D;
      m_pend = 8'((int'(bus.mul_a) * int'(bus.mul_b) * 3) % 13);
    end
  end

  task automatic start_run(input logic [3:0] e);
    @(negedge clk);
    bus.base_m  = 8'd5;
    bus.one_m   = 8'd9;
    bus.m       = 8'd13;
    bus.exp     = e;
    bus.start_p = 1'b1;
    @(posedge clk);
    #1;
    t0 = n_edges;
    bus.start_p = 1'b0;
    bus.base_m  = 8'hFF;
    bus.one_m   = 8'hFF;
    bus.m       = 8'hFF;
    bus.exp     = 4'hF;
    pulses.delete();
    n_done   = 0;
    done_cyc = -1;
  endtask

  task automatic wait_done(input int restart_cyc);
    int k = 0;
    while (n_done == 0 && k < 200) begin
      @(negedge clk);
      #1;
      if (restart_cyc > 0 && (n_edges - t0 + 1) == restart_cyc) begin
        bus.exp     = 4'hF;
        bus.start_p = 1'b1;
      end else begin
        bus.start_p = 1'b0;
      end
      k++;
    end
    bus.start_p = 1'b0;
    if (n_done == 0) check("done_timeout", 0, 1);
  endtask

  task automatic check_run(input string tag, input int np, input int first,
                           input int dcyc, input logic [7:0] res);
    check({tag, "_npulse"}, pulses.size(), np);
    foreach (pulses[i]) check({tag, "_pulse_cyc"}, pulses[i], first + 4 * i);
    check({tag, "_done_cyc"}, done_cyc, dcyc);
    check({tag, "_result"}, done_res, res);
    check({tag, "_busy_at_done"}, done_busy, 1);
    @(negedge clk);
    #1;
    check({tag, "_busy_after"}, bus.busy, 0);
    check({tag, "_done_after"}, bus.done_p, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.start_p = 1'b0;
    bus.base_m  = '0;
    bus.one_m   = '0;
    bus.m       = '0;
    bus.exp     = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("rst_result", bus.result, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done_p, 0);
    check("rst_en", bus.mul_enable_p, 0);
    check("rst_mul_a", bus.mul_a, 0);
    check("rst_mul_b", bus.mul_b, 0);
    check("rst_mul_m", bus.mul_m, 0);
    @(negedge clk);
    rst_n = 1'b1;

    start_run(4'd5);
    wait_done(0);
    check_run("e5", E5_NP, E5_FIRST, E5_DONE, 8'h02);

    start_run(4'd5);
    wait_done(4);
    check_run("e5_restart", E5_NP, E5_FIRST, E5_DONE, 8'h02);

    n_done = 0;
    @(posedge clk);
    #1;
    inj = 1'b1;
    @(posedge clk);
    #1;
    inj = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_inj_result", bus.result, 8'h02);
    check("idle_inj_nodone", n_done, 0);
    check("idle_inj_busy", bus.busy, 0);

    start_run(4'd0);
    wait_done(0);
    check_run("e0", E0_NP, 1, E0_DONE, 8'h09);

    start_run(4'd5);
    for (int k = 0; k < 50 && (n_edges - t0 + 1) != 10; k++) @(negedge clk);
    check("mid_mul_m", bus.mul_m, 8'd13);
    check("mid_busy", bus.busy, 1);
    rst_n = 1'b0;
    #1;
    check("arst_result", bus.result, 0);
    check("arst_busy", bus.busy, 0);
    check("arst_done", bus.done_p, 0);
    check("arst_en", bus.mul_enable_p, 0);
    check("arst_mul_a", bus.mul_a, 0);
    check("arst_mul_b", bus.mul_b, 0);
    check("arst_mul_m", bus.mul_m, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n_done = 0;
    repeat (6) @(negedge clk);
    #1;
    check("late_nodone", n_done, 0);
    check("late_result", bus.result, 0);
    check("late_busy", bus.busy, 0);

    start_run(4'd5);
    wait_done(0);
    check_run("e5_post_rst", E5_NP, E5_FIRST, E5_DONE, 8'h02);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
